// File: rtl/param_ram_arbiter_pkg.sv
// Shared types and constants for the parameter-RAM arbiter.
// Optional macro PARAM_ARB_RR_EN (used by param_ram_arbiter) selects round-robin tie-break.
package param_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGnt0,
    StGnt1
  } arb_state_e;

  // Requester IDs carried through the response pipeline
  localparam logic REQ_ADC = 1'b0;
  localparam logic REQ_SNS = 1'b1;

  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_RD_LAT    = 1;
  localparam int unsigned DEF_MAX_BURST = 16;

endpackage

// File: rtl/param_rsp_pipe.sv
// Delay line tracking in-flight RAM reads: valid and requester ID, RD_LAT stages deep.
module param_rsp_pipe
  import param_ram_arbiter_pkg::*;
#(
  parameter int unsigned RD_LAT = DEF_RD_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_id,
  output logic out_valid,
  output logic out_id,
  output logic any_valid
);

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] id_q;

  // Shift one stage per cycle; reset discards every read in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q[0] <= in_valid;
      id_q[0]  <= in_id;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[RD_LAT-1];
  assign out_id    = id_q[RD_LAT-1];
  assign any_valid = |vld_q;

endmodule

// File: rtl/param_ram_arbiter.sv
// Two-requester read arbiter for the shared parameter RAM.
// Macro PARAM_ARB_RR_EN: when defined, IDLE ties go to the requester not granted last;
// otherwise requester 1 wins ties. Burst preemption at MAX_BURST applies in both builds.
module param_ram_arbiter
  import param_ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned RD_LAT    = DEF_RD_LAT,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e        state_q;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic [CNT_W-1:0]  beat_cnt_nxt;
  logic              beat;
  logic              beat_id;
  logic [ADDR_W-1:0] beat_addr;
  logic              other_valid;
  logic              preempt;
  logic              enter;
  logic              enter_id;
  logic              tie_winner;
  logic              pipe_valid;
  logic              pipe_id;
  logic              pipe_busy;
  logic [DATA_W-1:0] rsp0_data_q;
  logic [DATA_W-1:0] rsp1_data_q;

`ifdef PARAM_ARB_RR_EN
  logic last_q;
  assign tie_winner = ~last_q;
`else
  assign tie_winner = REQ_SNS;
`endif

  // Beat decode: the granted requester's valid is a RAM read this very cycle
  always_comb begin
    beat        = 1'b0;
    beat_id     = REQ_ADC;
    beat_addr   = '0;
    other_valid = 1'b0;
    unique case (state_q)
      StGnt0: begin
        beat        = req0_valid;
        beat_id     = REQ_ADC;
        beat_addr   = req0_valid ? req0_addr : '0;
        other_valid = req1_valid;
      end
      StGnt1: begin
        beat        = req1_valid;
        beat_id     = REQ_SNS;
        beat_addr   = req1_valid ? req1_addr : '0;
        other_valid = req0_valid;
      end
      default: ;
    endcase
  end

  assign beat_cnt_nxt = (beat_cnt_q == CNT_W'(MAX_BURST)) ? beat_cnt_q
                                                          : beat_cnt_q + CNT_W'(1);
  // Hand over once this beat brings the burst to its limit and the other side is waiting
  assign preempt = beat && other_valid && (beat_cnt_nxt == CNT_W'(MAX_BURST));

  // Grant entry decision: from IDLE on any request, or a preemptive switch
  always_comb begin
    enter    = 1'b0;
    enter_id = REQ_ADC;
    if (state_q == StIdle) begin
      enter    = req0_valid || req1_valid;
      enter_id = (req0_valid && req1_valid) ? tie_winner : req1_valid;
    end else if (preempt) begin
      enter    = 1'b1;
      enter_id = ~beat_id;
    end
  end

  // Arbitration FSM with beat counter (and last-granted tracking when round-robin)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
`ifdef PARAM_ARB_RR_EN
      last_q     <= 1'b1;
`endif
    end else if (enter) begin
      state_q    <= enter_id ? StGnt1 : StGnt0;
      beat_cnt_q <= '0;
`ifdef PARAM_ARB_RR_EN
      last_q     <= enter_id;
`endif
    end else if (state_q != StIdle && !beat) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
    end else if (beat) begin
      beat_cnt_q <= beat_cnt_nxt;
    end
  end

  assign req0_ready = beat && (beat_id == REQ_ADC);
  assign req1_ready = beat && (beat_id == REQ_SNS);
  assign ram_en     = beat;
  assign ram_addr   = beat_addr;

  param_rsp_pipe #(
    .RD_LAT(RD_LAT)
  ) u_rsp_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (beat),
    .in_id    (beat_id),
    .out_valid(pipe_valid),
    .out_id   (pipe_id),
    .any_valid(pipe_busy)
  );

  assign rsp0_valid = pipe_valid && (pipe_id == REQ_ADC);
  assign rsp1_valid = pipe_valid && (pipe_id == REQ_SNS);

  // Hold the last delivered word per requester between strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_data_q <= '0;
      rsp1_data_q <= '0;
    end else begin
      if (rsp0_valid) rsp0_data_q <= ram_dout;
      if (rsp1_valid) rsp1_data_q <= ram_dout;
    end
  end

  // RAM data passes straight through on the strobe cycle
  assign rsp0_data = rsp0_valid ? ram_dout : rsp0_data_q;
  assign rsp1_data = rsp1_valid ? ram_dout : rsp1_data_q;

  assign busy = (state_q != StIdle) || pipe_busy;

endmodule

// File: doc/param_ram_arbiter.md
PARAM_RAM_ARBITER -- requirements
Module: param_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning parameter-RAM word address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning parameter-RAM word width.
REQ-003 SHALL have parameter RD_LAT, default 1, meaning RAM read latency in cycles (legal range 1..3).
REQ-004 SHALL have parameter MAX_BURST, default 16, meaning the most consecutive beats one grant may hold while the other requester waits.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports req0_valid/req1_valid, input, 1, read request from requester 0 (ADC config) and requester 1 (sensor config).
REQ-008 SHALL have ports req0_addr/req1_addr, input, ADDR_W, read address for each requester.
REQ-009 SHALL have ports req0_ready/req1_ready, output, 1, high when that requester's request is accepted this cycle.
REQ-010 SHALL have ports rsp0_valid/rsp1_valid, output, 1, one-cycle strobe qualifying read data.
REQ-011 SHALL have ports rsp0_data/rsp1_data, output, DATA_W, read data, stable until the next strobe to that requester.
REQ-012 SHALL have port ram_en, output, 1, RAM read enable; ram_addr, output, ADDR_W; ram_dout, input, DATA_W.
REQ-013 SHALL have port busy, output, 1, high in any grant state or while a read is in flight.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, GNT0, GNT1.
REQ-015 IDLE: any reqN_valid SHALL move to GNTN on the next edge; with both valid, the winner follows REQ-030.
REQ-016 In GNTN, every cycle with reqN_valid high SHALL be one beat: reqN_ready=1, ram_en=1, ram_addr=reqN_addr, all combinational in that cycle.
REQ-017 The grant SHALL release to IDLE when reqN_valid drops, and to the other grant state when the other requester is waiting and the beat count reaches MAX_BURST.
REQ-018 The beat counter SHALL reset to 0 on every grant entry and SHALL saturate at MAX_BURST.
REQ-019 The non-granted requester SHALL see ready=0; its requests SHALL never reach the RAM.
REQ-020 Each beat SHALL push its requester ID into an RD_LAT-deep valid/ID pipeline; exactly RD_LAT cycles after the beat, rspN_valid=1 and rspN_data=ram_dout for that ID.
REQ-021 Responses SHALL return in issue order; back-to-back beats SHALL give back-to-back strobes with no bubble.
REQ-022 Switching grant SHALL insert no idle cycle beyond the single FSM transition; in-flight responses SHALL still route to the original issuer.
REQ-023 busy SHALL remain high until the last in-flight strobe has been issued.

Reset
REQ-024 Asserting rst SHALL immediately drive state=IDLE, beat count 0, pipeline cleared, ram_en=0, ram_addr=0, ready/rsp_valid=0, rsp_data=0, busy=0.
REQ-025 Reads in flight at reset SHALL be discarded; no strobe SHALL follow reset deassertion.
REQ-026 Requests SHALL be ignored during reset; after release, arbitration SHALL start from IDLE on the first clock edge.

Configuration
REQ-027 Macro PARAM_ARB_RR_EN SHALL select the arbitration policy.
REQ-028 With PARAM_ARB_RR_EN defined: a one-bit last-granted register SHALL exist; a tie in IDLE SHALL go to the requester not granted last; the register SHALL reset to 1, so requester 0 wins the first tie.
REQ-029 Without PARAM_ARB_RR_EN: fixed priority SHALL apply, with requester 1 winning ties; the MAX_BURST preemption of REQ-017 SHALL still apply.
REQ-030 The tie-break rule in IDLE SHALL be exactly the one defined by REQ-028/REQ-029.

Structure
REQ-031 A shared package SHALL hold the FSM state enumeration, requester-ID constants (REQ_ADC=0, REQ_SNS=1) and the default widths.
REQ-032 The response pipeline SHALL be a sub-module param_rsp_pipe (parameter RD_LAT; input valid/ID; output delayed valid/ID); the FSM, counter and muxes SHALL stay in the top module.

Verification
REQ-033 Single requester, RD_LAT=1: req0 reads addresses 0x00..0x03 back-to-back -> four consecutive ready beats; rsp0_valid 1 cycle after each; data equals RAM contents; rsp1_valid never asserts.
REQ-034 Simultaneous first requests from IDLE -> with PARAM_ARB_RR_EN, req0 granted first; without it, req1 granted first.
REQ-035 req0 holds valid for 40 beats while req1 is waiting, MAX_BURST=16 -> grant switches to GNT1 after beat 16; req0's 16 responses still arrive on rsp0.
REQ-036 RD_LAT=3, grant switch mid-stream -> every response reaches its issuer exactly 3 cycles after its beat, in order, with no loss.
REQ-037 rst pulsed with 2 reads in flight -> no rsp strobe afterwards; busy=0; next request is granted from IDLE.
REQ-038 req1 drops valid after 5 beats with req0 idle -> FSM returns to IDLE; busy falls RD_LAT cycles after the last beat.
